// File: rtl/siso_frame_pkg.sv
// Shared types and line-level constants for the SISO frame receiver.
// Optional parity stage is enabled with SISO_FRAME_RECEIVER_PARITY_EN.
package siso_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/frame_bit_counter.sv
// Data-bit position counter for the frame receiver.
// Cleared on start bit, advanced per sampled data bit.
module frame_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_inc,
    output logic [$clog2(WIDTH)-1:0] o_count,
    output logic                     o_last
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/siso_frame_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, stop bit.
// Define SISO_FRAME_RECEIVER_PARITY_EN to add an even-parity bit before stop.
module siso_frame_receiver
    import siso_frame_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_en,
    input  logic                 serial_in,
    output logic [WIDTH-1:0]     data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CW = $clog2(WIDTH);

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_hold;
    logic [WIDTH-1:0]     r_data;
    logic                 r_valid;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_cnt;
    logic                 w_clr;
    logic                 w_inc;
    logic                 w_good;
    logic                 w_bad;
    logic                 w_par_err;
    logic [CW-1:0]        w_count;
    logic                 w_last;

    frame_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .o_count (w_count),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_inc  = 1'b0;
        w_good = 1'b0;
        w_bad  = 1'b0;
        if (bit_en) begin
            unique case (r_state)
                IDLE: begin
                    if (serial_in == START_BIT) begin
                        w_next = DATA;
                        w_clr  = 1'b1;
                    end
                end
                DATA: begin
                    w_inc = 1'b1;
                    if (w_last) begin
`ifdef SISO_FRAME_RECEIVER_PARITY_EN
                        w_next = PARITY;
`else
                        w_next = STOP;
`endif
                    end
                end
                PARITY: w_next = STOP;
                STOP: begin
                    // A 1 here is a broken stop bit, never a new start.
                    w_next = IDLE;
                    if (serial_in == STOP_BIT && !w_par_err) begin
                        w_good = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

`ifdef SISO_FRAME_RECEIVER_PARITY_EN
    logic r_par_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_err <= 1'b0;
        end else if (w_clr) begin
            r_par_err <= 1'b0;
        end else if (bit_en && r_state == PARITY) begin
            r_par_err <= serial_in ^ (^r_hold);
        end
    end

    assign w_par_err = r_par_err;
`else
    assign w_par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_valid <= w_good;
            r_err   <= w_bad;
            if (bit_en && r_state == DATA) begin
                r_hold[w_count] <= serial_in;
            end
            if (w_good) begin
                r_data <= r_hold;
            end
            if (w_bad && r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_err;
    assign busy       = (r_state != IDLE);
    assign err_count  = r_cnt;

endmodule
